// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    I_FILL  = 3'd1,
    D_FILL  = 3'd2,
    WRITE   = 3'd3,
    RELEASE = 3'd4
  } arb_state_e;

  localparam int BLOCK_WORDS_DEF = 8;

  // Values held in the round-robin last-fill flag.
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_beat_counter.sv
// Counts returning read beats of a fill; done fires on the beat that completes the block.
module arb_beat_counter #(
  parameter int CNT_W       = 4,
  parameter int BLOCK_WORDS = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    done  = inc && (cnt_q == CNT_W'(BLOCK_WORDS - 1));
    cnt_d = cnt_q;
    if (clr || done) cnt_d = '0;
    else if (inc)    cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory port between I-fill, D-fill and write-through stores.
// Define ARB_RR_EN to alternate I/D fills when both are pending; default is fixed wr > d > i.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int BLOCK_WORDS = BLOCK_WORDS_DEF,
  parameter int CNT_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_grant,
  output logic              i_data_valid,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_grant,
  output logic              d_data_valid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_enable,
  output logic              mem_wr,
  input  logic              mem_data_valid
);

  if ((1 << CNT_W) <= BLOCK_WORDS) begin : g_cnt_w_check
    $error("CNT_W too small for BLOCK_WORDS");
  end

  arb_state_e state_q, state_d;
  logic       in_fill, beat_inc, beat_done, d_wins;

  assign in_fill  = (state_q == I_FILL) || (state_q == D_FILL);
  assign beat_inc = in_fill && mem_data_valid;

  arb_beat_counter #(.CNT_W(CNT_W), .BLOCK_WORDS(BLOCK_WORDS)) u_beat_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (beat_inc),
    .clr  (!in_fill),
    .done (beat_done)
  );

`ifdef ARB_RR_EN
  logic last_fill_q, last_fill_d;

  // D wins a tie only if I won the previous contested-or-not fill.
  assign d_wins = d_req && (!i_req || (last_fill_q == OWN_I));

  always_comb begin
    last_fill_d = last_fill_q;
    if (state_q == IDLE && !wr_req && (d_req || i_req))
      last_fill_d = d_wins ? OWN_D : OWN_I;
  end

  always_ff @(posedge clk) begin
    if (rst) last_fill_q <= OWN_I;
    else     last_fill_q <= last_fill_d;
  end
`else
  assign d_wins = d_req;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (wr_req)      state_d = WRITE;
        else if (d_wins) state_d = D_FILL;
        else if (i_req)  state_d = I_FILL;
      end
      I_FILL, D_FILL: if (beat_done) state_d = RELEASE;
      default:        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    i_grant      = 1'b0;
    d_grant      = 1'b0;
    wr_ack       = 1'b0;
    i_data_valid = 1'b0;
    d_data_valid = 1'b0;
    mem_enable   = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    case (state_q)
      I_FILL: begin
        i_grant      = 1'b1;
        i_data_valid = mem_data_valid;
        mem_enable   = 1'b1;
        mem_addr     = i_addr;
      end
      D_FILL: begin
        d_grant      = 1'b1;
        d_data_valid = mem_data_valid;
        mem_enable   = 1'b1;
        mem_addr     = d_addr;
      end
      WRITE: begin
        wr_ack     = 1'b1;
        mem_enable = 1'b1;
        mem_wr     = 1'b1;
        mem_addr   = wr_addr;
        mem_wdata  = wr_data;
      end
      default: ;
    endcase
  end

endmodule
